fetch_stage: RTL and testbench

//  Fetch stage: generates PC, issues imem requests, takes in-order imem responses and

---
 rtl/fetch_stage.sv | 248 ++++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Generates the fetch PC, issues instruction-memory requests under a credit
//   limit, collects in-order responses and hands {instr, pc, pc+4, vld} to the
//   decode stage through a small response FIFO. Redirects come from decode
//   (JAL) and execute (branch/JALR, higher priority). Responses that were
//   already in flight at a redirect are discarded using a drop counter.
//
// Parameters
//   N_BITS     datapath / address width
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  response FIFO depth = max credits (power of 2, >= 2)
//
// Ports
//   clk, rst_n                        clock (rising edge), sync active-low reset
//   imem_req_vld/rdy/addr             instruction memory request channel
//   imem_rsp_vld/data                 in-order response, no backpressure
//   D_jal_vld/tgt                     decode-stage JAL redirect
//   X_redirect_vld/tgt                execute-stage branch/JALR redirect
//   stall_in                          decode stall
//   nxt_instr/pc_out/pc_plus4_out     FIFO head presented to decode
//   vld_out                           head valid
//
// Configuration
//   FETCH_PERF_CNT_EN  when defined adds perf_fetch_cnt (pops) and
//                      perf_drop_cnt (discarded responses), both 32 bit.
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned          N_BITS    = 32,
    parameter logic [N_BITS-1:0]    RESET_PC  = '0,
    parameter int unsigned          BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_vld,
    input  logic              imem_req_rdy,
    output logic [N_BITS-1:0] imem_req_addr,
    input  logic              imem_rsp_vld,
    input  logic [N_BITS-1:0] imem_rsp_data,
    input  logic              D_jal_vld,
    input  logic [N_BITS-1:0] D_jal_tgt,
    input  logic              X_redirect_vld,
    input  logic [N_BITS-1:0] X_redirect_tgt,
    input  logic              stall_in,
    output logic [N_BITS-1:0] nxt_instr,
    output logic [N_BITS-1:0] pc_out,
    output logic [N_BITS-1:0] pc_plus4_out,
    output logic              vld_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_drop_cnt
`endif
);

    localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [N_BITS-1:0] pc_q, pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

    // PCs of requests still awaiting their response
    logic [N_BITS-1:0] iq_pc_q [BUF_DEPTH];
    logic [N_BITS-1:0] iq_pc_d [BUF_DEPTH];
    logic [AW-1:0]     iq_wr_q, iq_wr_d;
    logic [AW-1:0]     iq_rd_q, iq_rd_d;

    // Response FIFO towards decode
    logic [N_BITS-1:0] fifo_instr_q [BUF_DEPTH];
    logic [N_BITS-1:0] fifo_instr_d [BUF_DEPTH];
    logic [N_BITS-1:0] fifo_pc_q    [BUF_DEPTH];
    logic [N_BITS-1:0] fifo_pc_d    [BUF_DEPTH];
    logic [N_BITS-1:0] fifo_pc4_q   [BUF_DEPTH];
    logic [N_BITS-1:0] fifo_pc4_d   [BUF_DEPTH];
    logic [AW-1:0]     fifo_wr_q, fifo_wr_d;
    logic [AW-1:0]     fifo_rd_q, fifo_rd_d;
    logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0]       perf_drop_cnt_q, perf_drop_cnt_d;
`endif

    logic              redir;
    logic [N_BITS-1:0] redir_tgt;
    logic              credit_ok;
    logic              req_vld;
    logic              fire;
    logic              fifo_empty;
    logic              out_vld;
    logic              pop;
    logic              push;
    logic [N_BITS-1:0] rsp_pc;

    always_comb begin
        redir      = X_redirect_vld | D_jal_vld;
        redir_tgt  = X_redirect_vld ? X_redirect_tgt : D_jal_tgt;
        credit_ok  = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < DEPTH_C;
        req_vld    = (state_q == ST_RUN) && !redir && credit_ok;
        fire       = req_vld && imem_req_rdy;
        fifo_empty = (fifo_cnt_q == '0);
        out_vld    = !fifo_empty && !redir;
        pop        = out_vld && !stall_in;
        rsp_pc     = iq_pc_q[iq_rd_q];
        // A response is kept only if it belongs to the current fetch stream
        push       = imem_rsp_vld && !redir && (drop_cnt_q == '0);
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inflight_d   = inflight_q;
        drop_cnt_d   = drop_cnt_q;
        iq_pc_d      = iq_pc_q;
        iq_wr_d      = iq_wr_q;
        iq_rd_d      = iq_rd_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_pc4_d   = fifo_pc4_q;
        fifo_wr_d    = fifo_wr_q;
        fifo_rd_d    = fifo_rd_q;
        fifo_cnt_d   = fifo_cnt_q;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

        if (redir) begin
            pc_d = redir_tgt;
        end else if (fire) begin
            pc_d = pc_q + N_BITS'(4);
        end

        if (fire) begin
            iq_pc_d[iq_wr_q] = pc_q;
            iq_wr_d          = iq_wr_q + AW'(1);
        end
        if (imem_rsp_vld) begin
            iq_rd_d = iq_rd_q + AW'(1);
        end

        inflight_d = inflight_q + CW'(fire) - CW'(imem_rsp_vld);

        // drop_cnt always counts a subset of inflight, so on a redirect every
        // response still outstanding after this cycle becomes stale.
        if (redir) begin
            if (imem_rsp_vld && (inflight_q == '0)) begin
                drop_cnt_d = '0;
            end else begin
                drop_cnt_d = inflight_q - CW'(imem_rsp_vld);
            end
        end else if (imem_rsp_vld && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end

        if (redir) begin
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (push) begin
                fifo_instr_d[fifo_wr_q] = imem_rsp_data;
                fifo_pc_d[fifo_wr_q]    = rsp_pc;
                fifo_pc4_d[fifo_wr_q]   = rsp_pc + N_BITS'(4);
                fifo_wr_d               = fifo_wr_q + AW'(1);
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + AW'(1);
            end
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q;
        perf_drop_cnt_d  = perf_drop_cnt_q;
        if (pop) begin
            perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
        end
        if (imem_rsp_vld && !push) begin
            perf_drop_cnt_d = perf_drop_cnt_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            inflight_q   <= '0;
            drop_cnt_q   <= '0;
            iq_pc_q      <= '{default: '0};
            iq_wr_q      <= '0;
            iq_rd_q      <= '0;
            fifo_instr_q <= '{default: '0};
            fifo_pc_q    <= '{default: '0};
            fifo_pc4_q   <= '{default: '0};
            fifo_wr_q    <= '0;
            fifo_rd_q    <= '0;
            fifo_cnt_q   <= '0;
`ifdef FETCH_PERF_CNT_EN
            perf_fetch_cnt_q <= '0;
            perf_drop_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inflight_q   <= inflight_d;
            drop_cnt_q   <= drop_cnt_d;
            iq_pc_q      <= iq_pc_d;
            iq_wr_q      <= iq_wr_d;
            iq_rd_q      <= iq_rd_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_pc4_q   <= fifo_pc4_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            fifo_cnt_q   <= fifo_cnt_d;
`ifdef FETCH_PERF_CNT_EN
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_drop_cnt_q  <= perf_drop_cnt_d;
`endif
        end
    end

    assign imem_req_vld  = req_vld;
    assign imem_req_addr = pc_q;
    assign nxt_instr     = fifo_instr_q[fifo_rd_q];
    assign pc_out        = fifo_pc_q[fifo_rd_q];
    // Stored per entry so that it reads 0 out of reset like the other outputs
    assign pc_plus4_out  = fifo_pc4_q[fifo_rd_q];
    assign vld_out       = out_vld;
`ifdef FETCH_PERF_CNT_EN
    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_drop_cnt  = perf_drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int unsigned NB = 32;
    localparam int unsigned BD = 2;

    logic          clk            = 1'b0;
    logic          rst_n          = 1'b0;
    logic          imem_req_vld;
    logic          imem_req_rdy   = 1'b1;
    logic [NB-1:0] imem_req_addr;
    logic          imem_rsp_vld   = 1'b0;
    logic [NB-1:0] imem_rsp_data  = '0;
    logic          D_jal_vld      = 1'b0;
    logic [NB-1:0] D_jal_tgt      = '0;
    logic          X_redirect_vld = 1'b0;
    logic [NB-1:0] X_redirect_tgt = '0;
    logic          stall_in       = 1'b1;
    logic [NB-1:0] nxt_instr;
    logic [NB-1:0] pc_out;
    logic [NB-1:0] pc_plus4_out;
    logic          vld_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_drop_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .N_BITS   (NB),
        .RESET_PC (32'h0),
        .BUF_DEPTH(BD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_vld  (imem_req_vld),
        .imem_req_rdy  (imem_req_rdy),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_vld  (imem_rsp_vld),
        .imem_rsp_data (imem_rsp_data),
        .D_jal_vld     (D_jal_vld),
        .D_jal_tgt     (D_jal_tgt),
        .X_redirect_vld(X_redirect_vld),
        .X_redirect_tgt(X_redirect_tgt),
        .stall_in      (stall_in),
        .nxt_instr     (nxt_instr),
        .pc_out        (pc_out),
        .pc_plus4_out  (pc_plus4_out),
        .vld_out       (vld_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_drop_cnt (perf_drop_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // PCs decode must receive, in order
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend_q[$];

    int          cyc        = 0;
    int          last_due   = 0;
    int          rsp_delay  = 1;
    bit          rand_rdy   = 1'b0;
    bit          rand_delay = 1'b0;
    bit          rand_stall = 1'b0;
    logic [31:0] exp_fire   = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d outputs still pending after %0d cycles, required 0", name, exp_q.size(), max_cyc);
            exp_q.delete();
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Instruction memory model plus decode stall driver
    always @(posedge clk) begin
        #1;
        imem_rsp_vld  = 1'b0;
        imem_rsp_data = '0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_vld  = 1'b1;
            imem_rsp_data = instr_of(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
        imem_req_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        stall_in     = (exp_q.size() == 0) || (rand_stall && ($urandom_range(0, 3) == 0));
    end

    // Request acceptance: address sequence and credit limit
    always @(negedge clk) begin
        int    d;
        int    due;
        pend_t p;
        if (rst_n && imem_req_vld && imem_req_rdy) begin
            check_eq("fire_addr", imem_req_addr, exp_fire);
            exp_fire = exp_fire + 32'd4;
            d   = rand_delay ? int'($urandom_range(1, 3)) : rsp_delay;
            due = cyc + d;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            p.addr = imem_req_addr;
            p.due  = due;
            pend_q.push_back(p);
            check_eq("credits_in_flight", 32'(pend_q.size() <= BD), 32'd1);
        end
    end

    // Scoreboard monitor: compares every accepted output against the queue
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && vld_out && !stall_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc_out %h required no output", pc_out);
            end else begin
                e = exp_q.pop_front();
                check_eq("pc_out", pc_out, e);
                check_eq("nxt_instr", nxt_instr, instr_of(e));
                check_eq("pc_plus4_out", pc_plus4_out, e + 32'd4);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_vld_out", 32'(vld_out), 32'd0);
        check_eq("rst_req_vld", 32'(imem_req_vld), 32'd0);
        check_eq("rst_req_addr", imem_req_addr, 32'h0);
        check_eq("rst_nxt_instr", nxt_instr, 32'h0);
        check_eq("rst_pc_out", pc_out, 32'h0);
        check_eq("rst_pc_plus4", pc_plus4_out, 32'h0);

        // Straight-line fetch from reset, first output in cycle 3
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) check_eq("boot_req_vld", 32'(imem_req_vld), 32'd0);
            if (c == 1) begin
                check_eq("first_req_vld", 32'(imem_req_vld), 32'd1);
                check_eq("first_req_addr", imem_req_addr, 32'h0);
            end
            check_eq("latency_vld_out", 32'(vld_out), (c == 3) ? 32'd1 : 32'd0);
        end
        wait_drain(200, "drain_linear");

        // Decode stall: credits exhausted, head held
        repeat (3) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_req_vld", 32'(imem_req_vld), 32'd0);
            check_eq("stall_vld_out", 32'(vld_out), 32'd1);
            check_eq("stall_pc_out", pc_out, 32'h20);
            check_eq("stall_nxt_instr", nxt_instr, instr_of(32'h20));
        end

        // X redirect to 0x80, then D JAL to 0x100 with two requests in flight
        rsp_delay = 3;
        @(posedge clk); #1;
        X_redirect_vld = 1'b1;
        X_redirect_tgt = 32'h80;
        exp_fire       = 32'h80;
        @(negedge clk);
        check_eq("xredir_vld_out", 32'(vld_out), 32'd0);
        check_eq("xredir_req_vld", 32'(imem_req_vld), 32'd0);
        @(posedge clk); #1;
        X_redirect_vld = 1'b0;
        for (int n = 0; n < 20 && pend_q.size() < 2; n++) begin
            @(posedge clk); #1;
        end
        check_eq("two_in_flight", 32'(pend_q.size()), 32'd2);
        D_jal_vld = 1'b1;
        D_jal_tgt = 32'h100;
        exp_fire  = 32'h100;
        @(negedge clk);
        check_eq("jal_req_vld", 32'(imem_req_vld), 32'd0);
        @(posedge clk); #1;
        D_jal_vld = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        wait_drain(300, "drain_jal");

        // Simultaneous X and D redirect: X wins, no output that cycle
        rsp_delay = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("pre_redir_vld_out", 32'(vld_out), 32'd1);
        check_eq("pre_redir_pc_out", pc_out, 32'h110);
        @(posedge clk); #1;
        X_redirect_vld = 1'b1;
        X_redirect_tgt = 32'h200;
        D_jal_vld      = 1'b1;
        D_jal_tgt      = 32'h300;
        exp_fire       = 32'h200;
        @(negedge clk);
        check_eq("both_redir_vld_out", 32'(vld_out), 32'd0);
        check_eq("both_redir_req_vld", 32'(imem_req_vld), 32'd0);
        @(posedge clk); #1;
        X_redirect_vld = 1'b0;
        D_jal_vld      = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(4 * i));
        wait_drain(200, "drain_both_redir");

        // Random ready, response delay and stall
        rand_rdy   = 1'b1;
        rand_delay = 1'b1;
        rand_stall = 1'b1;
        for (int i = 0; i < 24; i++) exp_q.push_back(32'h210 + 32'(4 * i));
        wait_drain(2000, "drain_random");
        rand_rdy   = 1'b0;
        rand_delay = 1'b0;
        rand_stall = 1'b0;

        // Reset mid-stream with FIFO full
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("full_vld_out", 32'(vld_out), 32'd1);
        check_eq("full_pc_out", pc_out, 32'h270);
        @(posedge clk); #1;
        rst_n = 1'b0;
        pend_q.delete();
        exp_fire = 32'h0;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_vld_out", 32'(vld_out), 32'd0);
        check_eq("mid_rst_req_addr", imem_req_addr, 32'h0);
        check_eq("mid_rst_req_vld", 32'(imem_req_vld), 32'd0);
        check_eq("mid_rst_pc_out", pc_out, 32'h0);
        check_eq("mid_rst_nxt_instr", nxt_instr, 32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reboot_req_vld", 32'(imem_req_vld), 32'd0);
        @(negedge clk);
        check_eq("reboot_first_req_vld", 32'(imem_req_vld), 32'd1);
        wait_drain(200, "drain_reboot");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
